apu_frame_counter: RTL and testbench
====================================

APU_FRAME_COUNTER -- requirements
Module: apu_frame_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 15, width of the APU-cycle step counter (minimum 15).
REQ-002 SHALL have port clk  input  1  system clock; all flops on its rising edge.
REQ-003 SHALL have port n_reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ce  input  1  APU-cycle enable, one clk wide, nominally every second CPU cycle.
REQ-005 SHALL have port wr  input  1  write strobe for the $4017 frame-counter register, one clk wide.
REQ-006 SHALL have port wr_data  input  8  write data; bit7 = mode (0 = 4-step, 1 = 5-step), bit6 = IRQ inhibit, bits 5:0 ignored.
REQ-007 SHALL have port status_rd  input  1  $4015 read strobe, one clk wide.
REQ-008 SHALL have port quarter  output  1  quarter-frame clock pulse (envelopes, linear counter) to channel blocks.
REQ-009 SHALL have port half  output  1  half-frame clock pulse (length counters, sweeps) to channel blocks.
REQ-010 SHALL have port irq_flag  output  1  frame IRQ flag, readable as $4015 bit6.
REQ-011 SHALL have port n_irq  output  1  active-low IRQ request to the CPU, equal to ~irq_flag.

Function
REQ-012 SHALL hold state: cnt (CNT_W bits), mode, inhibit, irq_flag, pend (pending write), pend_mode, pend_inh.
REQ-013 SHALL increment cnt by 1 on each clk edge with ce=1; no change when ce=0.
REQ-014 SHALL, in mode 0, wrap cnt from 14914 to 0; in mode 1, wrap cnt from 18640 to 0.
REQ-015 SHALL set step hits at ce edges where cnt equals: mode 0 -> 3728 Q, 7456 Q+H, 11185 Q, 14914 Q+H; mode 1 -> 3728 Q, 7456 Q+H, 11185 Q, 18640 Q+H (mode 1 has no hit at 14914).
REQ-016 SHALL register quarter/half high for exactly one clk after a ce edge that hits Q/H; both low in every other clk.
REQ-017 SHALL set irq_flag at the ce edge where cnt = 14914 in mode 0 with inhibit = 0.
REQ-018 SHALL clear irq_flag on the clk edge where status_rd = 1, unless REQ-017 sets it on the same edge (set wins).
REQ-019 SHALL, on wr, capture pend = 1 and pend_mode/pend_inh from wr_data[7:6]; if wr_data[6] = 1, clear irq_flag on the same edge.
REQ-020 SHALL apply a pending write at the first ce edge strictly after the wr edge: mode <= pend_mode, inhibit <= pend_inh, cnt <= 0, pend <= 0; normal step hits are suppressed on that edge.
REQ-021 SHALL, when the applied write has mode = 1, emit one quarter and one half pulse (REQ-016 timing) from that ce edge.
REQ-022 SHALL, when a second wr arrives while pend = 1, overwrite pend_mode/pend_inh (last write wins).
REQ-023 SHALL ignore wr_data[5:0]; the mode change takes effect only via REQ-020 (a stale mode never wraps past the new limit).

Reset
REQ-024 SHALL, while n_reset = 0, force cnt = 0, mode = 0, inhibit = 0, pend = 0, irq_flag = 0, quarter = 0, half = 0, n_irq = 1, independent of clk.
REQ-025 SHALL resume counting from cnt = 0 in mode 0 at the first ce edge after n_reset deasserts; a write pending at reset assertion is discarded.

Configuration
REQ-026 SHALL compile the IRQ logic (irq_flag, inhibit, REQ-017/018/019 clearing) only when APU_FRAME_IRQ_EN is defined.
REQ-027 SHALL, without APU_FRAME_IRQ_EN, tie irq_flag = 0 and n_irq = 1, ignore wr_data[6] and status_rd; quarter/half sequencing is unchanged.

Verification
REQ-028 SHALL cover: reset, ce every clk, mode 0 -> quarter pulses after ce edges at cnt 3728, 7456, 11185, 14914; half at 7456, 14914; cnt back to 0 after 14914.
REQ-029 SHALL cover: wr 0x80 -> one quarter+half pulse after the next ce edge, then hits at 3728/7456/11185/18640, no irq_flag.
REQ-030 SHALL cover: mode 0, inhibit 0 -> irq_flag = 1, n_irq = 0 after cnt 14914; status_rd -> irq_flag = 0 next clk.
REQ-031 SHALL cover: irq_flag = 1, wr 0x40 -> irq_flag = 0 on the wr edge; no further IRQ across 3 full frames.
REQ-032 SHALL cover: status_rd on the same edge as the 14914 hit -> irq_flag = 1; wr at cnt 7455 with ce = 0 -> no half pulse at 7456, cnt = 0 after the next ce.
REQ-033 SHALL cover: n_reset pulsed low mid-frame (cnt ~ 9000, pend = 1) -> all outputs at reset values immediately, first quarter 3728 ce edges after release.

Source files
------------

// File: rtl/apu_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : apu_frame_counter
// Description : APU frame sequencer ($4017). Counts APU cycles (ce) and emits
//               quarter-frame / half-frame clock pulses to the channel blocks
//               in either the 4-step (mode 0) or 5-step (mode 1) sequence,
//               and optionally raises the frame IRQ at the end of a 4-step
//               frame.
//
// Ports       : clk       - system clock, all flops on its rising edge
//               n_reset   - asynchronous active-low reset
//               ce        - APU-cycle enable, one clk wide
//               wr        - $4017 write strobe, one clk wide
//               wr_data   - [7] mode (1 = 5-step), [6] IRQ inhibit, [5:0] unused
//               status_rd - $4015 read strobe (acknowledges the frame IRQ)
//               quarter   - one-clk quarter-frame pulse
//               half      - one-clk half-frame pulse
//               irq_flag  - frame IRQ flag ($4015 bit 6)
//               n_irq     - active-low IRQ request, always ~irq_flag
//
// Config      : define APU_FRAME_IRQ_EN to build the frame IRQ logic. Without
//               it irq_flag is tied low, n_irq high, and wr_data[6] and
//               status_rd are ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module apu_frame_counter #(
    parameter int CNT_W = 15
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       ce,
    input  logic       wr,
    input  logic [7:0] wr_data,
    input  logic       status_rd,
    output logic       quarter,
    output logic       half,
    output logic       irq_flag,
    output logic       n_irq
);

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } mode_e;

    // Step positions in APU cycles from the start of the frame.
    localparam logic [CNT_W-1:0] c_STEP_1    = CNT_W'(3728);
    localparam logic [CNT_W-1:0] c_STEP_2    = CNT_W'(7456);
    localparam logic [CNT_W-1:0] c_STEP_3    = CNT_W'(11185);
    localparam logic [CNT_W-1:0] c_STEP_4_M0 = CNT_W'(14914);
    localparam logic [CNT_W-1:0] c_STEP_4_M1 = CNT_W'(18640);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    mode_e            pend_mode_q, pend_mode_d;
    logic             pend_q, pend_d;
    logic             quarter_q, quarter_d;
    logic             half_q, half_d;

    logic [CNT_W-1:0] w_limit;
    logic             w_last;
    logic             w_wrap;
    logic             w_hit_q;
    logic             w_hit_h;
    logic             w_unused;

    // ------------------------------------------------------------------------
    // Step decode on the current count
    // ------------------------------------------------------------------------
    assign w_limit = (mode_q == MODE_5STEP) ? c_STEP_4_M1 : c_STEP_4_M0;
    assign w_last  = (cnt_q == w_limit);
    // Wrap on >= so an out-of-range count can never run past the frame end.
    assign w_wrap  = (cnt_q >= w_limit);

    always_comb begin
        w_hit_q = 1'b0;
        w_hit_h = 1'b0;
        if (cnt_q == c_STEP_1 || cnt_q == c_STEP_3) begin
            w_hit_q = 1'b1;
        end
        if (cnt_q == c_STEP_2 || w_last) begin
            w_hit_q = 1'b1;
            w_hit_h = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        pend_d      = pend_q;
        pend_mode_d = pend_mode_q;
        quarter_d   = 1'b0;
        half_d      = 1'b0;

        if (ce) begin
            if (pend_q) begin
                // Deferred $4017 write: restart the frame, no normal step.
                // Entering 5-step mode clocks the units immediately.
                mode_d    = pend_mode_q;
                cnt_d     = '0;
                pend_d    = 1'b0;
                quarter_d = (pend_mode_q == MODE_5STEP);
                half_d    = (pend_mode_q == MODE_5STEP);
            end else begin
                quarter_d = w_hit_q;
                half_d    = w_hit_h;
                cnt_d     = w_wrap ? '0 : cnt_q + 1'b1;
            end
        end

        // A write on the same edge as an apply re-arms for the next ce edge.
        if (wr) begin
            pend_d      = 1'b1;
            pend_mode_d = mode_e'(wr_data[7]);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q       <= '0;
            mode_q      <= MODE_4STEP;
            pend_q      <= 1'b0;
            pend_mode_q <= MODE_4STEP;
            quarter_q   <= 1'b0;
            half_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            pend_mode_q <= pend_mode_d;
            quarter_q   <= quarter_d;
            half_q      <= half_d;
        end
    end

    assign quarter = quarter_q;
    assign half    = half_q;

    // ------------------------------------------------------------------------
    // Frame IRQ
    // ------------------------------------------------------------------------
`ifdef APU_FRAME_IRQ_EN
    logic inhibit_q, inhibit_d;
    logic pend_inh_q, pend_inh_d;
    logic irq_q, irq_d;
    logic w_irq_set;

    // Raised on the last step of a 4-step frame; never on an apply edge.
    assign w_irq_set = ce & ~pend_q & (mode_q == MODE_4STEP) & w_last & ~inhibit_q;

    always_comb begin
        inhibit_d  = inhibit_q;
        pend_inh_d = pend_inh_q;
        irq_d      = irq_q;

        if (ce && pend_q) begin
            inhibit_d = pend_inh_q;
        end
        if (wr) begin
            pend_inh_d = wr_data[6];
        end

        // Setting takes priority over any acknowledge on the same edge.
        if (w_irq_set) begin
            irq_d = 1'b1;
        end else if (status_rd || (wr && wr_data[6])) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            inhibit_q  <= 1'b0;
            pend_inh_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            inhibit_q  <= inhibit_d;
            pend_inh_q <= pend_inh_d;
            irq_q      <= irq_d;
        end
    end

    assign irq_flag = irq_q;
    assign n_irq    = ~irq_q;
    assign w_unused = ^wr_data[5:0];
`else
    assign irq_flag = 1'b0;
    assign n_irq    = 1'b1;
    assign w_unused = ^{wr_data[6:0], status_rd};
`endif

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apu_frame_counter
// Description : Self-checking bench for apu_frame_counter. A behavioural
//               frame model (step table + modulo counter) predicts quarter,
//               half, irq_flag and n_irq every clk; literal expectations at
//               the frame steps pin both the model and the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apu_frame_counter;

`ifdef APU_FRAME_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       n_reset   = 1'b1;
    logic       ce        = 1'b0;
    logic       wr        = 1'b0;
    logic [7:0] wr_data   = 8'h00;
    logic       status_rd = 1'b0;
    logic       quarter;
    logic       half;
    logic       irq_flag;
    logic       n_irq;

    int total = 0;
    int bad   = 0;

    apu_frame_counter #(.CNT_W(15)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .ce        (ce),
        .wr        (wr),
        .wr_data   (wr_data),
        .status_rd (status_rd),
        .quarter   (quarter),
        .half      (half),
        .irq_flag  (irq_flag),
        .n_irq     (n_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: step table, frame length = last step + 1
    // ------------------------------------------------------------------------
    function automatic int step_at(input bit md, input int i);
        case (i)
            0:       return 3728;
            1:       return 7456;
            2:       return 11185;
            default: return md ? 18640 : 14914;
        endcase
    endfunction

    int m_cnt,  nx_cnt;
    bit m_mode, nx_mode;
    bit m_inh,  nx_inh;
    bit m_irq,  nx_irq;
    bit m_pend, nx_pend;
    bit m_pm,   nx_pm;
    bit m_pi,   nx_pi;
    bit m_q,    nx_q;
    bit m_h,    nx_h;
    bit nx_set;

    always_comb begin
        nx_cnt  = m_cnt;
        nx_mode = m_mode;
        nx_inh  = m_inh;
        nx_irq  = m_irq;
        nx_pend = m_pend;
        nx_pm   = m_pm;
        nx_pi   = m_pi;
        nx_q    = 1'b0;
        nx_h    = 1'b0;
        nx_set  = 1'b0;
        if (ce) begin
            if (m_pend) begin
                nx_mode = m_pm;
                nx_inh  = m_pi;
                nx_cnt  = 0;
                nx_pend = 1'b0;
                nx_q    = m_pm;
                nx_h    = m_pm;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (m_cnt == step_at(m_mode, i)) begin
                        nx_q = 1'b1;
                        if (i % 2 == 1) nx_h = 1'b1;
                    end
                end
                nx_set = IRQ_ON && !m_mode && !m_inh && (m_cnt == step_at(1'b0, 3));
                nx_cnt = (m_cnt + 1) % (step_at(m_mode, 3) + 1);
            end
        end
        if (nx_set) nx_irq = 1'b1;
        else if (status_rd || (wr && wr_data[6])) nx_irq = 1'b0;
        if (wr) begin
            nx_pend = 1'b1;
            nx_pm   = wr_data[7];
            nx_pi   = wr_data[6];
        end
    end

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_cnt  <= 0;
            m_mode <= 1'b0;
            m_inh  <= 1'b0;
            m_irq  <= 1'b0;
            m_pend <= 1'b0;
            m_pm   <= 1'b0;
            m_pi   <= 1'b0;
            m_q    <= 1'b0;
            m_h    <= 1'b0;
        end else begin
            m_cnt  <= nx_cnt;
            m_mode <= nx_mode;
            m_inh  <= nx_inh;
            m_irq  <= nx_irq;
            m_pend <= nx_pend;
            m_pm   <= nx_pm;
            m_pi   <= nx_pi;
            m_q    <= nx_q;
            m_h    <= nx_h;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("quarter", quarter, m_q);
        chk("half", half, m_h);
        chk("irq_flag", irq_flag, m_irq);
        chk("n_irq", n_irq, !m_irq);
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic cyc(input bit c, input bit w, input logic [7:0] d, input bit r);
        ce        = c;
        wr        = w;
        wr_data   = w ? d : 8'($urandom);
        status_rd = r;
        @(posedge clk);
        #1;
        ce        = 1'b0;
        wr        = 1'b0;
        status_rd = 1'b0;
    endtask

    // n ce edges back to back; rd_pct = chance (%) of a stray $4015 read.
    task automatic run(input int n, input int rd_pct);
        repeat (n) cyc(1'b1, 1'b0, 8'h00, ($urandom_range(99) < rd_pct));
    endtask

    task automatic chk_qh(input string nm, input bit q, input bit h);
        chk({nm, "_q"}, quarter, q);
        chk({nm, "_h"}, half, h);
    endtask

    initial begin
        #1 n_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_qh("reset", 1'b0, 1'b0);
        chk("reset_irq", irq_flag, 0);
        chk("reset_nirq", n_irq, 1);
        n_reset = 1'b1;

        // 5-step mode: immediate pulse, then 3728/7456/11185/18640.
        cyc(1'b0, 1'b1, 8'h80, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk_qh("m1_apply", 1'b1, 1'b1);
        chk("m1_apply_cnt", m_cnt, 0);
        run(3729, 5);  chk_qh("m1_3728", 1'b1, 1'b0);
        run(3728, 5);  chk_qh("m1_7456", 1'b1, 1'b1);
        run(3729, 5);  chk_qh("m1_11185", 1'b1, 1'b0);
        run(3729, 5);  chk_qh("m1_14914", 1'b0, 1'b0);
        run(3726, 5);  chk_qh("m1_18640", 1'b1, 1'b1);
        chk("m1_noirq", irq_flag, 0);
        chk("m1_wrap_cnt", m_cnt, 0);

        // Reset mid-frame with a write pending: outputs drop at once.
        run(7456, 0);
        cyc(1'b1, 1'b1, 8'h80, 1'b0);
        chk_qh("pre_rst", 1'b1, 1'b1);
        #2 n_reset = 1'b0;
        #1;
        chk_qh("async_rst", 1'b0, 1'b0);
        chk("async_rst_nirq", n_irq, 1);
        @(posedge clk);
        @(posedge clk);
        #1 n_reset = 1'b1;

        // 4-step frame from reset; pending 5-step write must be gone.
        run(1, 0);     chk_qh("rel_first", 1'b0, 1'b0);
        run(3728, 0);  chk_qh("m0_3728", 1'b1, 1'b0);
        run(3728, 0);  chk_qh("m0_7456", 1'b1, 1'b1);
        run(3729, 0);  chk_qh("m0_11185", 1'b1, 1'b0);
        run(3729, 0);  chk_qh("m0_14914", 1'b1, 1'b1);
        chk("m0_irq_set", irq_flag, IRQ_ON);
        chk("m0_nirq_set", n_irq, !IRQ_ON);
        chk("m0_wrap_cnt", m_cnt, 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rd_clear", irq_flag, 0);

        // Acknowledge on the very edge that raises the IRQ: set wins.
        run(14914, 0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        chk("set_wins", irq_flag, IRQ_ON);

        // Inhibit write at cnt 7455 (ce low): IRQ cleared, no half at 7456.
        run(7455, 0);
        chk("irq_held", irq_flag, IRQ_ON);
        cyc(1'b0, 1'b1, 8'h40, 1'b0);
        chk("wr40_clear", irq_flag, 0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk_qh("wr7455_apply", 1'b0, 1'b0);
        chk("wr7455_cnt", m_cnt, 0);

        // Three full inhibited 4-step frames: steps continue, no IRQ.
        for (int f = 0; f < 3; f++) begin
            run(14915, 5);
            chk_qh("inh_frame_end", 1'b1, 1'b1);
            chk("inh_noirq", irq_flag, 0);
        end

        // Random traffic on every input.
        repeat (3000) begin
            cyc(1'($urandom_range(1)), ($urandom_range(49) == 0),
                8'($urandom), ($urandom_range(19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
